// File: rtl/banked_stack_address_unit_if.sv
// Operation request/response bus between the control unit and banked_stack_address_unit.
interface banked_stack_address_unit_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  logic                  op_valid;
  logic                  op_ready;
  logic [1:0]            control;
  logic                  privilege_mode_flag;
  logic [DATA_WIDTH-1:0] input_address;
  logic [ADDR_WIDTH-1:0] output_address;
  logic                  address_valid;

  modport master (
    output op_valid, control, privilege_mode_flag, input_address,
    input  op_ready, output_address, address_valid
  );

  modport slave (
    input  op_valid, control, privilege_mode_flag, input_address,
    output op_ready, output_address, address_valid
  );
endinterface

// File: rtl/banked_stack_address_unit.sv
// Banked (privileged/user) stack pointer address unit with PC buffer.
// Optional macro STACK_FAULT_TRAP_EN makes stack_fault sticky until a privileged SP reload.
//
// state | meaning
// IDLE  | ready to accept an operation
// RESP  | registered result presented; address_valid unless the op faulted
module banked_stack_address_unit #(
  parameter int                        ADDR_WIDTH      = 14,
  parameter int                        DATA_WIDTH      = 32,
  parameter int                        CODE_AREA_SIZE  = 4096,
  parameter int                        PRIV_STACK_SIZE = 2048,
  parameter int                        USER_STACK_SIZE = 2048,
  parameter logic [DATA_WIDTH-1:0]     STACK_EMPTY     = '1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] current_PC,
  output logic [DATA_WIDTH-1:0] next_PC,
  output logic [ADDR_WIDTH-1:0] instruction_address,
  output logic [DATA_WIDTH-1:0] SP_out,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic                  stack_fault,
  banked_stack_address_unit_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0] PRIV_TOP = DATA_WIDTH'(CODE_AREA_SIZE);
  localparam logic [DATA_WIDTH-1:0] PRIV_BOT = DATA_WIDTH'(CODE_AREA_SIZE + PRIV_STACK_SIZE - 1);
  localparam logic [DATA_WIDTH-1:0] USER_TOP = DATA_WIDTH'(CODE_AREA_SIZE + PRIV_STACK_SIZE);
  localparam logic [DATA_WIDTH-1:0] USER_BOT = DATA_WIDTH'(CODE_AREA_SIZE + PRIV_STACK_SIZE + USER_STACK_SIZE - 1);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] priv_sp_q, priv_sp_d, user_sp_q, user_sp_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d, pc_q;
  logic                  addr_valid_q, addr_valid_d, fault_q, fault_d;

  logic                  sel_priv;
  logic [DATA_WIDTH-1:0] cur_sp, cur_top, cur_bot, new_sp;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic                  op_fault, op_addr_valid, load_ok, accept;

  assign sel_priv = bus.privilege_mode_flag;
  assign cur_sp   = sel_priv ? priv_sp_q : user_sp_q;
  assign cur_top  = sel_priv ? PRIV_TOP : USER_TOP;
  assign cur_bot  = sel_priv ? PRIV_BOT : USER_BOT;

  assign SP_out      = cur_sp;
  assign stack_empty = (cur_sp == STACK_EMPTY);
  assign stack_full  = (cur_sp == cur_top);
  assign stack_fault = fault_q;

  assign next_PC             = current_PC + 1'b1;
  assign instruction_address = pc_q;

  assign bus.output_address = out_addr_q;
  assign bus.address_valid  = addr_valid_q;

  assign load_ok = (bus.input_address == STACK_EMPTY) ||
                   ((bus.input_address >= cur_top) && (bus.input_address <= cur_bot));

`ifdef STACK_FAULT_TRAP_EN
  // While trapped only a privileged reload of a legal SP gets through.
  logic clear_load;
  assign clear_load   = (bus.control == 2'd3) && sel_priv && load_ok;
  assign accept       = (state_q == IDLE) && enable && bus.op_valid && (!fault_q || clear_load);
  assign bus.op_ready = (state_q == IDLE) && !fault_q;
`else
  assign accept       = (state_q == IDLE) && enable && bus.op_valid;
  assign bus.op_ready = (state_q == IDLE);
`endif

  always_comb begin
    new_sp        = cur_sp;
    op_addr       = '0;
    op_fault      = 1'b0;
    op_addr_valid = 1'b0;
    case (bus.control)
      2'd0: begin
        op_addr       = bus.input_address[ADDR_WIDTH-1:0];
        op_addr_valid = 1'b1;
      end
      2'd1: begin
        if (cur_sp == STACK_EMPTY)   new_sp = cur_bot;
        else if (cur_sp == cur_top)  op_fault = 1'b1;
        else                         new_sp = cur_sp - 1'b1;
        op_addr       = new_sp[ADDR_WIDTH-1:0];
        op_addr_valid = !op_fault;
      end
      2'd2: begin
        if (cur_sp == STACK_EMPTY)   op_fault = 1'b1;
        else if (cur_sp == cur_bot)  new_sp = STACK_EMPTY;
        else                         new_sp = cur_sp + 1'b1;
        op_addr       = cur_sp[ADDR_WIDTH-1:0];
        op_addr_valid = !op_fault;
      end
      default: begin
        new_sp   = load_ok ? bus.input_address : STACK_EMPTY;
        op_fault = !load_ok;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    priv_sp_d    = priv_sp_q;
    user_sp_d    = user_sp_q;
    out_addr_d   = out_addr_q;
    addr_valid_d = addr_valid_q;
    fault_d      = fault_q;
    if (accept) begin
      state_d      = RESP;
      addr_valid_d = op_addr_valid;
      fault_d      = op_fault;
      if (op_addr_valid) out_addr_d = op_addr;
      if (sel_priv) priv_sp_d = new_sp;
      else          user_sp_d = new_sp;
    end else if ((state_q == RESP) && enable) begin
      state_d      = IDLE;
      addr_valid_d = 1'b0;
`ifndef STACK_FAULT_TRAP_EN
      fault_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      priv_sp_q    <= STACK_EMPTY;
      user_sp_q    <= STACK_EMPTY;
      out_addr_q   <= '0;
      addr_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      pc_q         <= '0;
    end else begin
      state_q      <= state_d;
      priv_sp_q    <= priv_sp_d;
      user_sp_q    <= user_sp_d;
      out_addr_q   <= out_addr_d;
      addr_valid_q <= addr_valid_d;
      fault_q      <= fault_d;
      if (enable) pc_q <= current_PC[ADDR_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_banked_stack_address_unit.sv
// Directed, table-driven bench for banked_stack_address_unit.
module tb_banked_stack_address_unit;

  localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic [31:0] current_PC = '0;
  logic [31:0] next_PC, SP_out;
  logic [13:0] instruction_address;
  logic        stack_empty, stack_full, stack_fault;

  int checks = 0;
  int errors = 0;

  banked_stack_address_unit_if #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) bus ();

  banked_stack_address_unit dut (
    .clock               (clock),
    .reset               (reset),
    .enable              (enable),
    .current_PC          (current_PC),
    .next_PC             (next_PC),
    .instruction_address (instruction_address),
    .SP_out              (SP_out),
    .stack_empty         (stack_empty),
    .stack_full          (stack_full),
    .stack_fault         (stack_fault),
    .bus                 (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        priv;
    logic [1:0]  ctrl;
    logic [31:0] addr;
    logic        exp_valid;
    logic [13:0] exp_out;
    logic [31:0] exp_sp;
    logic        exp_empty;
    logic        exp_full;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the RESP cycle.
  task automatic issue(input logic p, input logic [1:0] c, input logic [31:0] a);
    bus.privilege_mode_flag = p;
    bus.control             = c;
    bus.input_address       = a;
    bus.op_valid            = 1'b1;
    @(negedge clock);
    bus.op_valid            = 1'b0;
  endtask

  initial begin
    int n;
    //          priv ctrl addr        valid out      sp       empty full
    vecs[0]  = '{1'b0, 2'd1, 32'd0,      1'b1, 14'd8191, 32'd8191, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 2'd1, 32'd0,      1'b1, 14'd8190, 32'd8190, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2'd2, 32'd0,      1'b1, 14'd8190, 32'd8191, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 2'd1, 32'd0,      1'b1, 14'd6143, 32'd6143, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 2'd1, 32'd0,      1'b1, 14'd6142, 32'd6142, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 2'd2, 32'd0,      1'b1, 14'd6142, 32'd6143, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 2'd2, 32'd0,      1'b1, 14'd6143, EMPTY,    1'b1, 1'b0};
    vecs[7]  = '{1'b0, 2'd0, 32'h12345,  1'b1, 14'h2345, 32'd8191, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 2'd3, 32'd7000,   1'b0, 14'd0,    32'd7000, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 2'd1, 32'd0,      1'b1, 14'd6999, 32'd6999, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 2'd3, 32'd4096,   1'b0, 14'd0,    32'd4096, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 2'd2, 32'd0,      1'b1, 14'd6999, 32'd7000, 1'b0, 1'b0};

    bus.op_valid = 1'b0;
    bus.control = 2'd0;
    bus.privilege_mode_flag = 1'b0;
    bus.input_address = '0;

    #12;
    chk("rst_op_ready", bus.op_ready, 1);
    chk("rst_addr_valid", bus.address_valid, 0);
    chk("rst_out_addr", bus.output_address, 0);
    chk("rst_fault", stack_fault, 0);
    chk("rst_user_sp", SP_out, EMPTY);
    chk("rst_empty", stack_empty, 1);
    bus.privilege_mode_flag = 1'b1;
    #1 chk("rst_priv_sp", SP_out, EMPTY);
    bus.privilege_mode_flag = 1'b0;
    chk("rst_instr_addr", instruction_address, 0);
    @(negedge clock);
    reset = 1'b1;

    // PC path: wrap and enable hold
    current_PC = 32'hFFFF_FFFF;
    #1 chk("next_pc_wrap", next_PC, 0);
    @(negedge clock);
    chk("instr_addr_load", instruction_address, 14'h3FFF);
    enable = 1'b0;
    current_PC = 32'd5;
    @(negedge clock);
    chk("instr_addr_hold", instruction_address, 14'h3FFF);
    chk("next_pc_plain", next_PC, 6);
    enable = 1'b1;

    for (int i = 0; i < 12; i++) begin
      chk($sformatf("v%0d_ready", i), bus.op_ready, 1);
      issue(vecs[i].priv, vecs[i].ctrl, vecs[i].addr);
      chk($sformatf("v%0d_valid", i), bus.address_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid)
        chk($sformatf("v%0d_addr", i), bus.output_address, vecs[i].exp_out);
      chk($sformatf("v%0d_sp", i), SP_out, vecs[i].exp_sp);
      chk($sformatf("v%0d_empty", i), stack_empty, vecs[i].exp_empty);
      chk($sformatf("v%0d_full", i), stack_full, vecs[i].exp_full);
      chk($sformatf("v%0d_fault", i), stack_fault, 0);
      chk($sformatf("v%0d_busy", i), bus.op_ready, 0);
      @(negedge clock);
      chk($sformatf("v%0d_pulse_end", i), bus.address_valid, 0);
    end

    // enable low during RESP holds address_valid; flag change doesn't affect op
    issue(1'b0, 2'd1, 32'd0);
    enable = 1'b0;
    bus.privilege_mode_flag = 1'b1;
    chk("stall_valid", bus.address_valid, 1);
    repeat (2) @(negedge clock);
    chk("stall_valid_held", bus.address_valid, 1);
    chk("stall_addr", bus.output_address, 6999);
    chk("stall_ready", bus.op_ready, 0);
    chk("stall_priv_sp", SP_out, 4096);
    bus.privilege_mode_flag = 1'b0;
    #1 chk("stall_user_sp", SP_out, 6999);
    enable = 1'b1;
    @(negedge clock);
    chk("stall_release_valid", bus.address_valid, 0);
    chk("stall_release_ready", bus.op_ready, 1);

    // push user bank down to its top, then overflow
    n = 0;
    while (SP_out != 32'd6144 && n < 3000) begin
      issue(1'b0, 2'd1, 32'd0);
      @(negedge clock);
      n++;
    end
    chk("push_loop_bound", (n < 3000), 1);
    chk("full_sp", SP_out, 6144);
    chk("full_flag", stack_full, 1);
    issue(1'b0, 2'd1, 32'd0);
    chk("ovf_fault", stack_fault, 1);
    chk("ovf_valid", bus.address_valid, 0);
    chk("ovf_sp", SP_out, 6144);
    @(negedge clock);
`ifdef STACK_FAULT_TRAP_EN
    chk("ovf_sticky", stack_fault, 1);
    chk("ovf_trap_ready", bus.op_ready, 0);
`else
    chk("ovf_pulse_end", stack_fault, 0);
    chk("ovf_ready", bus.op_ready, 1);
`endif
    issue(1'b1, 2'd3, 32'd5000);
    chk("clr1_fault", stack_fault, 0);
    chk("clr1_sp", SP_out, 5000);
    @(negedge clock);
    chk("clr1_ready", bus.op_ready, 1);

    // underflow on empty privileged bank
    issue(1'b1, 2'd3, EMPTY);
    @(negedge clock);
    issue(1'b1, 2'd2, 32'd0);
    chk("unf_fault", stack_fault, 1);
    chk("unf_valid", bus.address_valid, 0);
    chk("unf_sp", SP_out, EMPTY);
    @(negedge clock);
`ifdef STACK_FAULT_TRAP_EN
    chk("unf_sticky", stack_fault, 1);
    issue(1'b0, 2'd1, 32'd0);
    chk("trap_block_valid", bus.address_valid, 0);
    chk("trap_block_ready", bus.op_ready, 0);
    bus.privilege_mode_flag = 1'b0;
    #1 chk("trap_block_sp", SP_out, 6144);
    @(negedge clock);
    chk("trap_still_ready", bus.op_ready, 0);
    issue(1'b1, 2'd3, 32'd5000);
    chk("clr2_fault", stack_fault, 0);
    @(negedge clock);
`else
    chk("unf_pulse_end", stack_fault, 0);
    chk("unf_ready", bus.op_ready, 1);
`endif

    // illegal SP load is coerced to empty
    issue(1'b0, 2'd3, 32'd100);
    chk("badload_fault", stack_fault, 1);
    chk("badload_sp", SP_out, EMPTY);
    chk("badload_valid", bus.address_valid, 0);
    @(negedge clock);
    issue(1'b1, 2'd3, 32'd5000);
    @(negedge clock);
    chk("clr3_ready", bus.op_ready, 1);
    bus.privilege_mode_flag = 1'b0;
    #1 chk("badload_user_empty", stack_empty, 1);

    // async reset in the middle of RESP
    @(negedge clock);
    issue(1'b0, 2'd1, 32'd0);
    chk("pre_rst_valid", bus.address_valid, 1);
    chk("pre_rst_addr", bus.output_address, 8191);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", bus.address_valid, 0);
    chk("mid_rst_ready", bus.op_ready, 1);
    chk("mid_rst_user_sp", SP_out, EMPTY);
    bus.privilege_mode_flag = 1'b1;
    #1 chk("mid_rst_priv_sp", SP_out, EMPTY);
    @(negedge clock);
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/banked_stack_address_unit.md
Name: banked_stack_address_unit

Overview:
- Successor to the single-SP memory address handler.
- Holds two banked stack pointers internally, one privileged and one user, instead of taking SP from the register file.
- Performs push/pop/load address math behind a valid/ready handshake with registered outputs. Reports full/empty/fault status per bank.
- Sits between the control unit and data memory. Also buffers the instruction address and produces the incremented PC.

Parameters:
- ADDR_WIDTH, 14, memory address width.
- DATA_WIDTH, 32, register/PC/SP width.
- CODE_AREA_SIZE, 4096, words reserved for code; privileged stack top = CODE_AREA_SIZE.
- PRIV_STACK_SIZE, 2048, privileged stack depth in words.
- USER_STACK_SIZE, 2048, user stack depth in words; user stack top = CODE_AREA_SIZE+PRIV_STACK_SIZE.
- STACK_EMPTY, all ones (DATA_WIDTH bits), sentinel SP value meaning "bank empty".

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  global advance; when low, no state changes.
- privilege_mode_flag  in  1  1 = privileged bank, 0 = user bank; sampled at op acceptance.
- op_valid  in  1  operation request.
- op_ready  out  1  unit can accept an operation.
- control  in  2  0 = direct, 1 = push, 2 = pop, 3 = load SP.
- input_address  in  DATA_WIDTH  direct address (op 0) or new SP value (op 3).
- current_PC  in  DATA_WIDTH  PC from the register file.
- next_PC  out  DATA_WIDTH  current_PC+1; combinational.
- instruction_address  out  ADDR_WIDTH  registered PC for instruction fetch.
- output_address  out  ADDR_WIDTH  registered data-memory address.
- address_valid  out  1  one-cycle pulse: output_address is valid.
- SP_out  out  DATA_WIDTH  SP of the currently selected bank.
- stack_empty  out  1  selected bank SP == STACK_EMPTY.
- stack_full  out  1  selected bank SP == its top.
- stack_fault  out  1  overflow/underflow indication.

Behaviour:
- Reset (reset=0, async):
  - both SPs = STACK_EMPTY; pc buffer = 0; state IDLE.
  - output_address = 0; address_valid = 0; stack_fault = 0; op_ready = 1.
- Bank bounds. Bottom is the first slot used; the stack grows toward top.
  - privileged: top = CODE_AREA_SIZE, bottom = CODE_AREA_SIZE+PRIV_STACK_SIZE-1.
  - user: top = CODE_AREA_SIZE+PRIV_STACK_SIZE, bottom = top+USER_STACK_SIZE-1.
- FSM states:
  - IDLE: op_ready = 1. On op_valid && enable, the op is accepted and the state moves to RESP.
  - RESP: op_ready = 0. address_valid = 1 for exactly this cycle unless the op faulted. Next edge with enable returns to IDLE.
  - Throughput is one op per 2 cycles; latency is 1 cycle from acceptance to address_valid.
- Ops, evaluated at acceptance on the bank selected then:
  - op 0 (direct): output_address = input_address[ADDR_WIDTH-1:0]; SP unchanged.
  - op 1 (push), by SP state:
    - SP == STACK_EMPTY: SP = bottom.
    - SP > top: SP = SP-1.
    - SP == top (full): overflow; SP unchanged; no address_valid.
    - output_address = new SP.
  - op 2 (pop), by SP state:
    - SP == STACK_EMPTY: underflow; no address_valid.
    - SP < bottom: SP = SP+1.
    - SP == bottom: SP = STACK_EMPTY.
    - output_address = old SP.
  - op 3 (load SP): selected SP = input_address. A value outside [top,bottom] that is not STACK_EMPTY is stored as STACK_EMPTY and raises a fault. No address_valid.
- Bank isolation: the unselected bank's SP never changes.
- privilege_mode_flag changing while in RESP does not affect the in-flight op.
- enable low:
  - freezes the FSM, SPs and pc buffer.
  - address_valid, if in RESP, stays asserted until enable returns.
- PC path:
  - pc buffer <= current_PC[ADDR_WIDTH-1:0] on each rising edge with enable; instruction_address = pc buffer.
  - next_PC = current_PC+1, modulo 2^DATA_WIDTH (all ones wraps to 0).
- Status: stack_empty, stack_full and SP_out are combinational from the selected bank.
- Fault without the optional feature: stack_fault is a one-cycle pulse in RESP.
- Reset mid-operation: returns to IDLE immediately; the pending op is discarded.

Optional Feature:
- Macro: STACK_FAULT_TRAP_EN.
- Defined:
  - stack_fault is sticky.
  - While set, op_ready = 0 and all push/pop/load ops are blocked.
  - Cleared only by an op-3 load of a valid SP with privilege_mode_flag=1, accepted despite op_ready=0. The clearing load itself executes normally.
- Undefined: fault is a one-cycle pulse only; subsequent ops proceed normally.

Test Plan:
- Reset, then user push ×1 -> address_valid 1 cycle later, output_address = 8191, SP_out = 8191, stack_empty 0.
- User push until SP = 6144, then one more push -> stack_full 1, stack_fault pulses, no address_valid, SP stays 6144.
- Privileged push, push, pop, pop -> addresses 6143, 6142, 6142, 6143; final SP = STACK_EMPTY; user SP untouched.
- Pop on empty bank -> stack_fault, no address_valid. With STACK_FAULT_TRAP_EN, op_ready stays 0 until a privileged load of 5000 clears it.
- current_PC = 0xFFFFFFFF with enable=1 -> next_PC = 0, instruction_address = 0x3FFF after the edge. With enable=0, instruction_address is held.
- Assert reset during RESP after a push -> immediately address_valid 0, both SPs STACK_EMPTY, op_ready 1.
